// File: rtl/rtc_key_scheduler_if.sv
// Configuration / key-offer port bundle for rtc_key_scheduler.
// key_par exists only when RTC_KEYSCHED_PARITY_EN is defined.
interface rtc_key_scheduler_if #(
    parameter int unsigned KEY_W    = 8,
    parameter int unsigned NUM_KEYS = 4
);
    localparam int unsigned IDX_W = (NUM_KEYS > 1) ? $clog2(NUM_KEYS) : 1;

    logic             cfg_enable;
    logic             cfg_we;
    logic [IDX_W-1:0] cfg_addr;
    logic [KEY_W-1:0] cfg_data;
    logic [KEY_W-1:0] key_out;
    logic [IDX_W-1:0] key_idx;
    logic             key_valid;
    logic             key_ack;
    logic             missed;
`ifdef RTC_KEYSCHED_PARITY_EN
    logic             key_par;
`endif

    // Driver side: configuration plus the key consumer.
    modport master (
        output cfg_enable, cfg_we, cfg_addr, cfg_data, key_ack,
        input  key_out, key_idx, key_valid, missed
`ifdef RTC_KEYSCHED_PARITY_EN
        , input key_par
`endif
    );

    // Scheduler side.
    modport slave (
        input  cfg_enable, cfg_we, cfg_addr, cfg_data, key_ack,
        output key_out, key_idx, key_valid, missed
`ifdef RTC_KEYSCHED_PARITY_EN
        , output key_par
`endif
    );
endinterface

// File: rtl/rtc_key_scheduler.sv
// Key-rotation controller: offers the next table key every TICKS_PER_CHANGE key_clk edges.
// Optional feature: define RTC_KEYSCHED_PARITY_EN to add the registered key_par output.
module rtc_key_scheduler #(
    parameter int unsigned KEY_W            = 8,
    parameter int unsigned NUM_KEYS         = 4,
    parameter int unsigned TICKS_PER_CHANGE = 1
) (
    input logic                sys_clk,
    input logic                rst_n,
    input logic                key_clk,
    rtc_key_scheduler_if.slave bus
);
    localparam int unsigned IDX_W = (NUM_KEYS > 1) ? $clog2(NUM_KEYS) : 1;
    localparam int unsigned CNT_W = (TICKS_PER_CHANGE > 1) ? $clog2(TICKS_PER_CHANGE) : 1;

    typedef enum logic [1:0] {IDLE, PRESENT, RUN} state_t;

    state_t           state_q, state_d;
    logic             prev_q;
    logic [CNT_W-1:0] cnt_q, cnt_d;
    logic [IDX_W-1:0] idx_q, idx_d;
    logic [KEY_W-1:0] key_q, key_d;
    logic             valid_q, valid_d;
    logic             missed_q, missed_d;
    logic [KEY_W-1:0] key_tbl [NUM_KEYS];

    logic             edge_c;
    logic             tick_c;
    logic [IDX_W-1:0] next_idx_c;
    logic [KEY_W-1:0] slot0_key_c;
    logic [KEY_W-1:0] next_key_c;

    assign edge_c     = key_clk & ~prev_q;
    // An edge arriving together with the ack already belongs to RUN.
    assign tick_c     = edge_c & ((state_q == RUN) | ((state_q == PRESENT) & bus.key_ack));
    assign next_idx_c = idx_q + IDX_W'(1);

    // Loads see a same-cycle table write (write-through).
    assign slot0_key_c = (bus.cfg_we && (bus.cfg_addr == '0)) ? bus.cfg_data : key_tbl[0];
    assign next_key_c  = (bus.cfg_we && (bus.cfg_addr == next_idx_c)) ? bus.cfg_data
                                                                      : key_tbl[next_idx_c];

    always_ff @(posedge sys_clk or negedge rst_n) begin
        if (!rst_n) begin
            for (int i = 0; i < int'(NUM_KEYS); i++) key_tbl[i] <= '0;
        end else if (bus.cfg_we) begin
            key_tbl[bus.cfg_addr] <= bus.cfg_data;
        end
    end

    always_ff @(posedge sys_clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q  <= IDLE;
            prev_q   <= 1'b1;
            cnt_q    <= '0;
            idx_q    <= '0;
            key_q    <= '0;
            valid_q  <= 1'b0;
            missed_q <= 1'b0;
        end else begin
            state_q  <= state_d;
            prev_q   <= key_clk;
            cnt_q    <= cnt_d;
            idx_q    <= idx_d;
            key_q    <= key_d;
            valid_q  <= valid_d;
            missed_q <= missed_d;
        end
    end

    always_comb begin
        state_d  = state_q;
        cnt_d    = cnt_q;
        idx_d    = idx_q;
        key_d    = key_q;
        valid_d  = valid_q;
        missed_d = missed_q;

        if (!bus.cfg_enable) begin
            state_d = IDLE;
            valid_d = 1'b0;
            idx_d   = '0;
            cnt_d   = '0;
        end else begin
            case (state_q)
                IDLE: begin
                    state_d  = PRESENT;
                    key_d    = slot0_key_c;
                    idx_d    = '0;
                    cnt_d    = '0;
                    missed_d = 1'b0;
                    valid_d  = 1'b1;
                end
                PRESENT: begin
                    if (bus.key_ack) begin
                        state_d = RUN;
                        valid_d = 1'b0;
                    end else if (edge_c) begin
                        missed_d = 1'b1;
                    end
                end
                RUN:     valid_d = 1'b0;
                default: state_d = IDLE;
            endcase

            // Counted edge: either advance to the next slot or bump the tick count.
            if (tick_c) begin
                if (cnt_q == CNT_W'(TICKS_PER_CHANGE - 1)) begin
                    state_d = PRESENT;
                    idx_d   = next_idx_c;
                    key_d   = next_key_c;
                    cnt_d   = '0;
                    valid_d = 1'b1;
                end else begin
                    cnt_d = cnt_q + CNT_W'(1);
                end
            end
        end
    end

    assign bus.key_out   = key_q;
    assign bus.key_idx   = idx_q;
    assign bus.key_valid = valid_q;
    assign bus.missed    = missed_q;

`ifdef RTC_KEYSCHED_PARITY_EN
    logic par_q;

    always_ff @(posedge sys_clk or negedge rst_n) begin
        if (!rst_n) par_q <= 1'b0;
        else        par_q <= ^key_d;
    end

    assign bus.key_par = par_q;
`endif
endmodule

// File: tb/tb_rtc_key_scheduler.sv
// Bench for rtc_key_scheduler: directed scenarios on TICKS_PER_CHANGE=1 and =3 instances,
// then randomized traffic against a behavioural model of the rotation rules.
module tb_rtc_key_scheduler;
    localparam int T1 = 1;

    logic       sys_clk = 1'b0;
    logic       rst_n = 1'b1;
    logic       kclk = 1'b0;
    logic       en1 = 1'b0, ack1 = 1'b0, en3 = 1'b0, ack3 = 1'b0;
    logic       we = 1'b0;
    logic [1:0] addr = 2'd0;
    logic [7:0] data = 8'd0;
    int         n_cmp = 0;
    int         n_err = 0;
    logic [7:0] tbl_init [4] = '{8'hA1, 8'hB2, 8'hC3, 8'hD4};

    always #5 sys_clk = ~sys_clk;

    rtc_key_scheduler_if #(.KEY_W(8), .NUM_KEYS(4)) if1 ();
    rtc_key_scheduler_if #(.KEY_W(8), .NUM_KEYS(4)) if3 ();

    assign if1.cfg_enable = en1;
    assign if1.cfg_we     = we;
    assign if1.cfg_addr   = addr;
    assign if1.cfg_data   = data;
    assign if1.key_ack    = ack1;
    assign if3.cfg_enable = en3;
    assign if3.cfg_we     = we;
    assign if3.cfg_addr   = addr;
    assign if3.cfg_data   = data;
    assign if3.key_ack    = ack3;

    rtc_key_scheduler #(.KEY_W(8), .NUM_KEYS(4), .TICKS_PER_CHANGE(1)) dut1 (
        .sys_clk(sys_clk), .rst_n(rst_n), .key_clk(kclk), .bus(if1.slave));
    rtc_key_scheduler #(.KEY_W(8), .NUM_KEYS(4), .TICKS_PER_CHANGE(3)) dut3 (
        .sys_clk(sys_clk), .rst_n(rst_n), .key_clk(kclk), .bus(if3.slave));

    // Observed {valid, idx, key, missed}
    logic [11:0] obs1, obs3;
    assign obs1 = {if1.key_valid, if1.key_idx, if1.key_out, if1.missed};
    assign obs3 = {if3.key_valid, if3.key_idx, if3.key_out, if3.missed};

    // Behavioural model of the TICKS_PER_CHANGE=1 instance.
    logic [7:0] m_tbl [4];
    logic [7:0] m_key;
    int         m_idx, m_cnt;
    bit         m_pend, m_missed, m_active, m_prev;

    function automatic logic [7:0] m_slot(int s);
        return (we && addr == 2'(s)) ? data : m_tbl[s];
    endfunction

    task automatic model_reset();
        for (int i = 0; i < 4; i++) m_tbl[i] = 8'h00;
        m_key = 8'h00; m_idx = 0; m_cnt = 0;
        m_pend = 0; m_missed = 0; m_active = 0; m_prev = 1;
    endtask

    task automatic model_step();
        bit edge_seen;
        bit counted;
        edge_seen = kclk && !m_prev;
        if (!en1) begin
            m_active = 0; m_pend = 0; m_idx = 0; m_cnt = 0;
        end else if (!m_active) begin
            m_active = 1; m_pend = 1; m_idx = 0; m_cnt = 0; m_missed = 0;
            m_key = m_slot(0);
        end else begin
            counted = edge_seen && (!m_pend || ack1);
            if (m_pend && ack1) m_pend = 0;
            else if (m_pend && edge_seen) m_missed = 1;
            if (counted) begin
                m_cnt = m_cnt + 1;
                if (m_cnt == T1) begin
                    m_cnt = 0;
                    m_idx = (m_idx + 1) % 4;
                    m_key = m_slot(m_idx);
                    m_pend = 1;
                end
            end
        end
        if (we) m_tbl[addr] = data;
        m_prev = kclk;
    endtask

    task automatic cyc();
        @(posedge sys_clk);
        #1;
    endtask

    task automatic load_table();
        for (int i = 0; i < 4; i++) begin
            we = 1'b1; addr = 2'(i); data = tbl_init[i];
            cyc();
        end
        we = 1'b0;
    endtask

    task automatic test_reset();
        logic [11:0] exp;
        rst_n = 1'b1;
        #1;
        rst_n = 1'b0;
        cyc();
        cyc();
        exp = 12'h000;
        n_cmp++;
        if (obs1 !== exp) begin n_err++; $display("FAIL reset_t1: got %h want %h", obs1, exp); end
        n_cmp++;
        if (obs3 !== exp) begin n_err++; $display("FAIL reset_t3: got %h want %h", obs3, exp); end
        rst_n = 1'b1;
        cyc();
        load_table();
    endtask

    task automatic test_rotation();
        logic [11:0] exp;
        en1 = 1'b1;
        cyc();
        exp = {1'b1, 2'd0, 8'hA1, 1'b0};
        n_cmp++;
        if (obs1 !== exp) begin n_err++; $display("FAIL rot_first: got %h want %h", obs1, exp); end
        ack1 = 1'b1; cyc(); ack1 = 1'b0;
        exp = {1'b0, 2'd0, 8'hA1, 1'b0};
        n_cmp++;
        if (obs1 !== exp) begin n_err++; $display("FAIL rot_ack0: got %h want %h", obs1, exp); end
        for (int i = 1; i <= 5; i++) begin
            kclk = 1'b1;
            cyc();
            exp = {1'b1, 2'(i % 4), tbl_init[i % 4], 1'b0};
            n_cmp++;
            if (obs1 !== exp) begin n_err++; $display("FAIL rot_offer%0d: got %h want %h", i, obs1, exp); end
            kclk = 1'b0; ack1 = 1'b1;
            cyc();
            ack1 = 1'b0;
            exp = {1'b0, 2'(i % 4), tbl_init[i % 4], 1'b0};
            n_cmp++;
            if (obs1 !== exp) begin n_err++; $display("FAIL rot_ack%0d: got %h want %h", i, obs1, exp); end
        end
    endtask

    task automatic test_missed();
        logic [11:0] exp;
        en1 = 1'b0;
        cyc();
        exp = {1'b0, 2'd0, 8'hB2, 1'b0};
        n_cmp++;
        if (obs1 !== exp) begin n_err++; $display("FAIL miss_idle: got %h want %h", obs1, exp); end
        en1 = 1'b1;
        cyc();
        for (int i = 0; i < 2; i++) begin
            kclk = 1'b1; cyc();
            kclk = 1'b0; cyc();
        end
        exp = {1'b1, 2'd0, 8'hA1, 1'b1};
        n_cmp++;
        if (obs1 !== exp) begin n_err++; $display("FAIL miss_hold: got %h want %h", obs1, exp); end
        ack1 = 1'b1; cyc(); ack1 = 1'b0;
        exp = {1'b0, 2'd0, 8'hA1, 1'b1};
        n_cmp++;
        if (obs1 !== exp) begin n_err++; $display("FAIL miss_ack: got %h want %h", obs1, exp); end
        kclk = 1'b1; cyc();
        exp = {1'b1, 2'd1, 8'hB2, 1'b1};
        n_cmp++;
        if (obs1 !== exp) begin n_err++; $display("FAIL miss_next: got %h want %h", obs1, exp); end
        kclk = 1'b0;
        en1 = 1'b0; cyc();
        en1 = 1'b1; cyc();
        exp = {1'b1, 2'd0, 8'hA1, 1'b0};
        n_cmp++;
        if (obs1 !== exp) begin n_err++; $display("FAIL miss_clear: got %h want %h", obs1, exp); end
        en1 = 1'b0; cyc();
    endtask

    task automatic test_kclk_high_at_reset();
        logic [11:0] exp;
        kclk = 1'b1;
        rst_n = 1'b0;
        cyc();
        rst_n = 1'b1;
        load_table();
        en1 = 1'b1; cyc();
        ack1 = 1'b1; cyc(); ack1 = 1'b0;
        cyc(); cyc(); cyc();
        exp = {1'b0, 2'd0, 8'hA1, 1'b0};
        n_cmp++;
        if (obs1 !== exp) begin n_err++; $display("FAIL high_noedge: got %h want %h", obs1, exp); end
        kclk = 1'b0; cyc();
        kclk = 1'b1; cyc();
        exp = {1'b1, 2'd1, 8'hB2, 1'b0};
        n_cmp++;
        if (obs1 !== exp) begin n_err++; $display("FAIL high_edge: got %h want %h", obs1, exp); end
        kclk = 1'b0; ack1 = 1'b1; cyc(); ack1 = 1'b0;
        en1 = 1'b0; cyc();
    endtask

    task automatic test_ticks3();
        logic [11:0] exp;
        logic [1:0]  eidx;
        en3 = 1'b1; cyc();
        exp = {1'b1, 2'd0, 8'hA1, 1'b0};
        n_cmp++;
        if (obs3 !== exp) begin n_err++; $display("FAIL t3_first: got %h want %h", obs3, exp); end
        ack3 = 1'b1; cyc(); ack3 = 1'b0;
        for (int e = 1; e <= 6; e++) begin
            kclk = 1'b1; cyc();
            eidx = (e >= 6) ? 2'd2 : (e >= 3) ? 2'd1 : 2'd0;
            exp = {(e == 3 || e == 6), eidx, tbl_init[eidx], 1'b0};
            n_cmp++;
            if (obs3 !== exp) begin n_err++; $display("FAIL t3_edge%0d: got %h want %h", e, obs3, exp); end
            kclk = 1'b0;
            ack3 = (e == 3 || e == 6);
            cyc();
            ack3 = 1'b0;
        end
        en3 = 1'b0; cyc();
    endtask

    task automatic test_write_through();
        logic [11:0] exp;
        en1 = 1'b1; cyc();
        ack1 = 1'b1; cyc(); ack1 = 1'b0;
        kclk = 1'b1; we = 1'b1; addr = 2'd1; data = 8'h5E;
        cyc();
        we = 1'b0; kclk = 1'b0;
        exp = {1'b1, 2'd1, 8'h5E, 1'b0};
        n_cmp++;
        if (obs1 !== exp) begin n_err++; $display("FAIL wt_load: got %h want %h", obs1, exp); end
        en1 = 1'b0; cyc();
        exp = {1'b0, 2'd0, 8'h5E, 1'b0};
        n_cmp++;
        if (obs1 !== exp) begin n_err++; $display("FAIL wt_disable: got %h want %h", obs1, exp); end
        we = 1'b1; addr = 2'd1; data = 8'hB2; cyc(); we = 1'b0;
    endtask

    task automatic test_parity_async_reset();
        logic [11:0] exp;
        en1 = 1'b1; cyc();
        ack1 = 1'b1; cyc(); ack1 = 1'b0;
        for (int i = 1; i <= 3; i++) begin
            kclk = 1'b1; cyc();
            exp = {1'b1, 2'(i), tbl_init[i], 1'b0};
            n_cmp++;
            if (obs1 !== exp) begin n_err++; $display("FAIL par_offer%0d: got %h want %h", i, obs1, exp); end
`ifdef RTC_KEYSCHED_PARITY_EN
            n_cmp++;
            if (if1.key_par !== ^tbl_init[i]) begin
                n_err++; $display("FAIL par_bit%0d: got %b want %b", i, if1.key_par, ^tbl_init[i]);
            end
`endif
            kclk = 1'b0;
            ack1 = (i < 3);
            cyc();
            ack1 = 1'b0;
        end
        #2;
        rst_n = 1'b0;
        #1;
        exp = 12'h000;
        n_cmp++;
        if (obs1 !== exp) begin n_err++; $display("FAIL async_rst: got %h want %h", obs1, exp); end
`ifdef RTC_KEYSCHED_PARITY_EN
        n_cmp++;
        if (if1.key_par !== 1'b0) begin n_err++; $display("FAIL async_par: got %b want 0", if1.key_par); end
`endif
        en1 = 1'b0;
        cyc();
    endtask

    task automatic test_random();
        logic [11:0] exp;
        int          bad;
        bad = 0;
        model_reset();
        kclk = 1'b0; en1 = 1'b0; ack1 = 1'b0; we = 1'b0;
        rst_n = 1'b1;
        for (int i = 0; i < 4; i++) begin
            we = 1'b1; addr = 2'(i); data = 8'($urandom);
            model_step();
            cyc();
        end
        we = 1'b0;
        for (int c = 0; c < 1500; c++) begin
            en1  = ($urandom_range(0, 99) < 97);
            if ($urandom_range(0, 2) == 0) kclk = ~kclk;
            ack1 = 1'($urandom_range(0, 1));
            we   = ($urandom_range(0, 9) == 0);
            addr = 2'($urandom);
            data = 8'($urandom);
            model_step();
            cyc();
            exp = {m_pend, 2'(m_idx), m_key, m_missed};
            n_cmp++;
            if (obs1 !== exp) begin
                n_err++;
                if (bad < 10) $display("FAIL rand_c%0d: got %h want %h", c, obs1, exp);
                bad++;
            end
`ifdef RTC_KEYSCHED_PARITY_EN
            n_cmp++;
            if (if1.key_par !== ^m_key) begin
                n_err++;
                if (bad < 10) $display("FAIL rand_par_c%0d: got %b want %b", c, if1.key_par, ^m_key);
                bad++;
            end
`endif
        end
    endtask

    initial begin
        test_reset();
        test_rotation();
        test_missed();
        test_kclk_high_at_reset();
        test_ticks3();
        test_write_through();
        test_parity_async_reset();
        test_random();
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end
endmodule
